// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Turns a host byte stream into instruction-memory writes and holds the core in
// reset until a complete, checksum-verified program image has been written.
//
// Stream format: [N] [word0 b3 b2 b1 b0] ... [wordN-1 b3..b0] [XOR checksum]
//   N          : word count, 1..DEPTH (not covered by the checksum)
//   words      : most-significant byte first
//   checksum   : XOR of every data byte
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse; begins a load from IDLE, DONE or ERR
//   byte_in/valid     stream byte and its qualifier
//   byte_ready        loader accepts a byte this cycle (COUNT, DATA, CSUM)
//   wr_en/addr/data   instruction memory write port, one-cycle strobe
//   cpu_hold          keep the core in reset
//   done / error      load verified / load failed (levels, mutually exclusive)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   // Word count needs one extra bit so that N == DEPTH fits.
   localparam int CW = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t             r_state;
   logic               r_byte_ready;
   logic               r_wr_en;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [WIDTH-1:0]   r_wr_data;
   logic               r_cpu_hold;
   logic               r_done;
   logic               r_error;
   logic [CW-1:0]      r_count;
   logic [ADDR_W-1:0]  r_word_idx;
   logic [1:0]         r_byte_idx;
   logic [WIDTH-9:0]   r_shift;      // first three bytes of the word in flight
   logic [7:0]         r_csum;

   logic w_hs;
   logic w_count_bad;
   logic w_last_word;

   // byte_ready is registered, so a handshake is simply valid & ready.
   assign w_hs        = byte_valid & r_byte_ready;
   assign w_count_bad = (byte_in == 8'd0) || (32'(byte_in) > DEPTH);
   assign w_last_word = ({1'b0, r_word_idx} == (r_count - CW'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_byte_ready <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_cpu_hold   <= 1'b1;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_count      <= '0;
         r_word_idx   <= '0;
         r_byte_idx   <= '0;
         r_shift      <= '0;
         r_csum       <= '0;
      end else begin
         r_wr_en <= 1'b0;   // strobe is a single cycle unless set below
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state      <= S_COUNT;
                  r_byte_ready <= 1'b1;
                  r_cpu_hold   <= 1'b1;
                  r_done       <= 1'b0;
                  r_error      <= 1'b0;
                  r_count      <= '0;
                  r_word_idx   <= '0;
                  r_byte_idx   <= '0;
                  r_csum       <= '0;
               end
            end
            S_COUNT: begin
               if (w_hs) begin
                  if (w_count_bad) begin
                     r_state      <= S_ERR;
                     r_byte_ready <= 1'b0;
                     r_error      <= 1'b1;
                  end else begin
                     r_count <= byte_in[CW-1:0];
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_hs) begin
                  r_csum <= r_csum ^ byte_in;
                  if (r_byte_idx == 2'd3) begin
                     r_wr_en    <= 1'b1;
                     r_wr_addr  <= r_word_idx;
                     r_wr_data  <= {r_shift, byte_in};
                     r_byte_idx <= '0;
                     r_word_idx <= r_word_idx + ADDR_W'(1);
                     // CSUM is entered on the same edge that raises the final wr_en.
                     if (w_last_word)
                        r_state <= S_CSUM;
                  end else begin
                     r_shift    <= {r_shift[WIDTH-17:0], byte_in};
                     r_byte_idx <= r_byte_idx + 2'd1;
                  end
               end
            end
            S_CSUM: begin
               if (w_hs) begin
                  r_byte_ready <= 1'b0;
                  if (byte_in == r_csum) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     r_error <= 1'b1;
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_byte_ready <= 1'b0;
               r_cpu_hold   <= 1'b1;
            end
         endcase
      end
   end

   assign byte_ready = r_byte_ready;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign cpu_hold   = r_cpu_hold;
   assign done       = r_done;
   assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench: expected memory writes are queued as each image is driven
// and popped by a write monitor whenever wr_en pulses. Status outputs are
// checked inline by each scenario task. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int n_vec    = 0;
   int n_bad    = 0;
   int n_writes = 0;

   logic [ADDR_W+WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0]        img[$];

   imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .byte_in   (byte_in),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      logic [ADDR_W+WIDTH-1:0] e;
      if (!rst && wr_en) begin
         n_writes++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               n_bad++;
               $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                        wr_addr, wr_data, e[ADDR_W+WIDTH-1:WIDTH], e[WIDTH-1:0]);
            end else
               $display("write addr=%0d data=%h ok", wr_addr, wr_data);
         end
      end
      if (!rst && done && error) begin
         n_bad++;
         $display("FAIL done_and_error: got done=1 error=1, required at most one");
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "watchdog");
   end

   // All stimulus tasks start and end just after a falling edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      n = 0;
      while (byte_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         n_vec++;
         n_bad++;
         $display("FAIL byte_timeout: byte_ready=%b, required 1 within 40 cycles", byte_ready);
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 3; k >= 0; k--)
         send_byte(w[8*k +: 8], gap);
   endtask

   function automatic logic [7:0] csum_of_img();
      logic [7:0] cs = 8'h00;
      foreach (img[i])
         cs = cs ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
      return cs;
   endfunction

   // Full image: count, words (expected writes queued), checksum ^ csum_xor.
   task automatic send_image(input int gap, input logic [7:0] csum_xor);
      send_byte(8'(img.size()), gap);
      foreach (img[i]) begin
         exp_q.push_back({ADDR_W'(i), img[i]});
         send_word(img[i], gap);
      end
      send_byte(csum_of_img() ^ csum_xor, gap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // status = {byte_ready, cpu_hold, done, error}
   task automatic test_reset();
      rst = 1'b1; byte_valid = 1'b1; byte_in = 8'hff;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error} !==
          {1'b0, 1'b0, {ADDR_W{1'b0}}, {WIDTH{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b we=%b a=%0d d=%h hold=%b done=%b err=%b, required 0 0 0 0 1 0 0",
                  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error} !== 4'b0100) begin
         n_bad++;
         $display("FAIL idle_ignores_byte: got status=%b, required 0100", {byte_ready, cpu_hold, done, error});
      end
      byte_valid = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_normal();
      img = '{32'h2800_0000, 32'h0840_0001};
      pulse_start();
      n_vec++;
      if ({byte_ready, cpu_hold, done, error} !== 4'b1100) begin
         n_bad++;
         $display("FAIL normal_after_start: got status=%b, required 1100", {byte_ready, cpu_hold, done, error});
      end
      send_image(0, 8'h00);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error} !== 4'b0010) begin
         n_bad++;
         $display("FAIL normal_done: got status=%b, required 0010", {byte_ready, cpu_hold, done, error});
      end
      @(negedge clk);
      n_vec++;
      if ({wr_en, wr_addr, exp_q.size() == 0} !== {1'b0, ADDR_W'(1), 1'b1}) begin
         n_bad++;
         $display("FAIL normal_addr_hold: got we=%b addr=%0d pending=%0d, required 0 1 0", wr_en, wr_addr, exp_q.size());
      end
      $display("test_normal done");
   endtask

   task automatic test_bad_count();
      int w0 = n_writes;
      pulse_start();
      send_byte(8'h00, 0);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, n_writes == w0} !== 5'b01011) begin
         n_bad++;
         $display("FAIL count_zero: got status=%b writes=%0d, required 0101 writes=0",
                  {byte_ready, cpu_hold, done, error}, n_writes - w0);
      end
      pulse_start();
      n_vec++;
      if ({byte_ready, cpu_hold, done, error} !== 4'b1100) begin
         n_bad++;
         $display("FAIL err_restart: got status=%b, required 1100", {byte_ready, cpu_hold, done, error});
      end
      send_byte(8'h11, 0);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, n_writes == w0} !== 5'b01011) begin
         n_bad++;
         $display("FAIL count_17: got status=%b writes=%0d, required 0101 writes=0",
                  {byte_ready, cpu_hold, done, error}, n_writes - w0);
      end
      $display("test_bad_count done");
   endtask

   task automatic test_csum_mismatch();
      img = '{32'h1234_5678};
      pulse_start();
      send_image(0, 8'h08);   // correct checksum is 0x08, so 0x00 is sent
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, exp_q.size() == 0} !== 5'b01011) begin
         n_bad++;
         $display("FAIL csum_mismatch: got status=%b pending=%0d, required 0101 pending=0",
                  {byte_ready, cpu_hold, done, error}, exp_q.size());
      end
      $display("test_csum_mismatch done");
   endtask

   task automatic test_gaps();
      int w0 = n_writes;
      img = '{32'h2800_0000, 32'h0840_0001};
      pulse_start();
      send_image(2, 8'h00);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, n_writes - w0 == 2} !== 5'b00101) begin
         n_bad++;
         $display("FAIL gaps: got status=%b writes=%0d, required 0010 writes=2",
                  {byte_ready, cpu_hold, done, error}, n_writes - w0);
      end
      $display("test_gaps done");
   endtask

   task automatic test_full_depth();
      int w0 = n_writes;
      img = {};
      for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
      pulse_start();
      send_image(0, 8'h00);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, n_writes - w0 == DEPTH, wr_addr} !==
          {5'b00101, ADDR_W'(DEPTH - 1)}) begin
         n_bad++;
         $display("FAIL full_depth: got status=%b writes=%0d addr=%0d, required 0010 writes=%0d addr=%0d",
                  {byte_ready, cpu_hold, done, error}, n_writes - w0, wr_addr, DEPTH, DEPTH - 1);
      end
      $display("test_full_depth done");
   endtask

   task automatic test_reset_midload();
      img = '{32'h2800_0000, 32'h0840_0001};
      pulse_start();
      send_byte(8'h02, 0);
      exp_q.push_back({ADDR_W'(0), img[0]});
      send_word(img[0], 0);
      send_byte(img[1][31:24], 0);
      send_byte(img[1][23:16], 0);
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, wr_en, wr_addr} !== {5'b01000, ADDR_W'(0)}) begin
         n_bad++;
         $display("FAIL midload_reset: got status=%b we=%b addr=%0d, required 0100 0 0",
                  {byte_ready, cpu_hold, done, error}, wr_en, wr_addr);
      end
      rst = 1'b0;
      pulse_start();
      send_image(0, 8'h00);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, exp_q.size() == 0} !== 5'b00101) begin
         n_bad++;
         $display("FAIL midload_reload: got status=%b pending=%0d, required 0010 pending=0",
                  {byte_ready, cpu_hold, done, error}, exp_q.size());
      end
      $display("test_reset_midload done");
   endtask

   task automatic test_reload();
      int w0;
      img = '{32'hdead_beef, 32'h0000_00a5};
      pulse_start();
      send_byte(8'h02, 0);
      exp_q.push_back({ADDR_W'(0), img[0]});
      exp_q.push_back({ADDR_W'(1), img[1]});
      send_byte(img[0][31:24], 0);
      send_byte(img[0][23:16], 0);
      pulse_start();          // must be ignored in DATA
      n_vec++;
      if ({byte_ready, cpu_hold, done, error} !== 4'b1100) begin
         n_bad++;
         $display("FAIL start_in_data: got status=%b, required 1100", {byte_ready, cpu_hold, done, error});
      end
      send_byte(img[0][15:8], 0);
      send_byte(img[0][7:0], 0);
      send_word(img[1], 0);
      send_byte(csum_of_img(), 0);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, exp_q.size() == 0} !== 5'b00101) begin
         n_bad++;
         $display("FAIL ignored_start_done: got status=%b pending=%0d, required 0010 pending=0",
                  {byte_ready, cpu_hold, done, error}, exp_q.size());
      end
      // Bytes offered in DONE are not consumed.
      w0 = n_writes;
      byte_in = 8'h01; byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, n_writes == w0} !== 5'b00101) begin
         n_bad++;
         $display("FAIL done_ignores_bytes: got status=%b, required 0010 no writes", {byte_ready, cpu_hold, done, error});
      end
      img = '{32'h1234_5678};
      pulse_start();
      n_vec++;
      if ({byte_ready, cpu_hold, done, error} !== 4'b1100) begin
         n_bad++;
         $display("FAIL restart_from_done: got status=%b, required 1100", {byte_ready, cpu_hold, done, error});
      end
      send_image(0, 8'h00);
      n_vec++;
      if ({byte_ready, cpu_hold, done, error, exp_q.size() == 0} !== 5'b00101) begin
         n_bad++;
         $display("FAIL reload_done: got status=%b pending=%0d, required 0010 pending=0",
                  {byte_ready, cpu_hold, done, error}, exp_q.size());
      end
      $display("test_reload done");
   endtask

   initial begin
      test_reset();
      test_normal();
      test_bad_count();
      test_csum_mismatch();
      test_gaps();
      test_full_depth();
      test_reset_midload();
      test_reload();
      repeat (4) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: takes a program image as a byte stream and writes it word by word into the instruction memory write port.
- Holds the core in reset (cpu_hold) until a complete, checksum-verified image has been written.
- Sits between the host byte link (UART RX or testbench) and the instruction memory write port.

Parameters:
- WIDTH, `WIDTH (32), instruction word width in bits; must equal 32.
- DEPTH, 16, number of instruction memory entries (`MEM_SIZE + 1).
- ADDR_W, 4, write address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  WIDTH  write data.
- cpu_hold  out  1  keep the core in reset.
- done  out  1  image loaded and verified; level.
- error  out  1  load failed; level.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, all counters and checksum cleared.
- Reset mid-load aborts immediately and gives the same values. Words already written stay in memory.
- A handshake (byte accepted) occurs when byte_valid and byte_ready are both 1 at a clock edge. Gaps in byte_valid of any length are legal.
- byte_ready is 1 in COUNT, DATA and CSUM, and 0 in all other states.
- All outputs are registered.
- IDLE: on start go to COUNT and clear done, error, checksum, byte index and word index.
- COUNT: first accepted byte is the word count N.
  - If N==0 or N>DEPTH, go to ERR.
  - Otherwise store N and go to DATA.
  - The count byte is not included in the checksum.
- DATA: bytes are assembled most-significant byte first, 4 bytes per word.
  - Each accepted byte is XORed into an 8-bit checksum.
  - On the 4th byte of a word, the next cycle has wr_en=1 for exactly one cycle, wr_data=assembled word, wr_addr=word index (0, 1, ...).
  - The word index increments after each write.
  - After word N-1 is accepted, go to CSUM.
  - Back-to-back bytes are legal; consecutive writes can therefore be 4 cycles apart.
- CSUM: next accepted byte is compared with the checksum.
  - Equal: go to DONE.
  - Not equal: go to ERR.
  - The CSUM state is entered in the same cycle the final wr_en pulses.
- DONE: done=1, cpu_hold=0.
- ERR: error=1, cpu_hold=1.
- done and error are never both 1.
- start is honoured in IDLE, DONE and ERR only.
  - In DONE or ERR it reasserts cpu_hold=1 and clears done/error on the next cycle.
  - Any start pulse in COUNT, DATA or CSUM is ignored.
- Bytes presented while byte_ready=0 are not consumed.
- wr_addr holds its last value when wr_en=0. wr_addr never exceeds DEPTH-1.
- Simultaneous start and a byte in IDLE: the byte is not accepted (byte_ready=0 in IDLE); the first byte is taken in COUNT.

Test Plan:
- Normal load: start, then bytes 02, 2800_0000, 0840_0001, checksum 0x61 -> writes addr0=0x28000000, addr1=0x08400001; done=1 and cpu_hold=0 one cycle after the checksum byte; error=0.
- Bad count: start, byte 00 -> error=1, no wr_en. Restart with start, byte 0x11 (17) -> error=1, cpu_hold=1.
- Checksum mismatch: valid 1-word image 0x12345678 with checksum 0x00 (correct value 0x08) -> word written at addr0, then error=1, done=0, cpu_hold=1.
- Backpressure/gaps: same 2-word image with byte_valid toggling 1 0 0 1 ... -> identical writes and final state to the back-to-back case; wr_en pulses exactly twice.
- Reset mid-load: assert rst after the 2nd byte of word 1 -> next cycle state IDLE, cpu_hold=1, done=0, byte_ready=0. A fresh full load then succeeds.
- Ignored start/reload: pulse start during DATA -> no effect. After DONE, start plus a 1-word image -> cpu_hold=1 and done=0 the cycle after start, then done=1 again after the checksum byte.
